net_drive_arbiter: RTL and testbench

Round-robin arbiter that shares one multi-driver net, such as a shared bus segment, among N_REQ requesting drivers. Only one driver is enabled at a time. A dead turnaround window separates successive owners so that two drivers never contend on the net. The block sits between the driver cells and the shared net and sequences every ownership change.

---
 rtl/net_drive_arbiter_if.sv | 32 +++
 rtl/net_drive_arbiter.sv | 141 ++++++++++++++
 tb/tb_net_drive_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/net_drive_arbiter_if.sv
// Handshake bundle between the driver cells and net_drive_arbiter.
// The arbiter connects through the slave modport; requesters use master.
interface net_drive_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             drv_en;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  drv_en,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output drv_en,
        output busy,
        output timeout
    );
endinterface

// File: rtl/net_drive_arbiter.sv
// Round-robin owner sequencer for a shared multi-driver net with a dead turnaround gap.
// Define ARB_HOLD_TIMEOUT_EN to force a release after MAX_HOLD cycles when others wait.
module net_drive_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                clk,
    input  logic                rst,
    net_drive_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 16 || TURNAROUND < 1 || TURNAROUND > 15 ||
        MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("net_drive_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [3:0]       r_turn_cnt, w_turn_cnt_nxt;
    logic [IDW-1:0]   w_win;
    logic             w_found;
    logic             w_force;

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [7:0]       r_hold_cnt, w_hold_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;

    // Forced release only matters while someone else is waiting for the net.
    assign w_force = (r_hold_cnt >= 8'(MAX_HOLD - 1)) && ((bus.req & ~r_gnt) != '0);
`else
    assign w_force = 1'b0;
`endif

    // Search starts at r_ptr and wraps with an explicit modulo for non-power-of-2 N_REQ.
    always_comb begin : arb_search
        logic [IDW-1:0] w_idx;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = IDW'((32'(r_ptr) + i) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_id_nxt   = r_gnt_id;
        w_ptr_nxt      = r_ptr;
        w_turn_cnt_nxt = r_turn_cnt;
`ifdef ARB_HOLD_TIMEOUT_EN
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
`endif
        case (r_state)
            GRANT: begin
                if (!bus.req[r_gnt_id] || w_force) begin
                    w_gnt_nxt      = '0;
                    w_ptr_nxt      = IDW'((32'(r_gnt_id) + 1) % N_REQ);
                    w_turn_cnt_nxt = 4'(TURNAROUND - 1);
                    w_state_nxt    = TURN;
`ifdef ARB_HOLD_TIMEOUT_EN
                    w_timeout_nxt  = w_force && bus.req[r_gnt_id];
`endif
                end
`ifdef ARB_HOLD_TIMEOUT_EN
                else if (r_hold_cnt != 8'hFF) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
`endif
            end
            IDLE, TURN: begin
                if (r_state == TURN && r_turn_cnt != '0) begin
                    w_turn_cnt_nxt = r_turn_cnt - 4'd1;
                end else if (w_found) begin
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_gnt_id_nxt     = w_win;
                    w_state_nxt      = GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
                    w_hold_cnt_nxt   = '0;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_ptr      <= '0;
            r_turn_cnt <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
`ifdef ARB_HOLD_TIMEOUT_EN
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
`endif
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.gnt_id = r_gnt_id;
    assign bus.drv_en = |r_gnt;
    assign bus.busy   = (r_state != IDLE);
`ifdef ARB_HOLD_TIMEOUT_EN
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_net_drive_arbiter.sv
// Directed and random checks of net_drive_arbiter against an owner/gap/priority model.
module tb_net_drive_arbiter;
    localparam int N   = 4;
    localparam int T   = 1;
    localparam int MH  = 16;
    localparam int BIG = 1000000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    net_drive_arbiter_if #(.N_REQ(N)) bus_if ();

    net_drive_arbiter #(
        .N_REQ      (N),
        .TURNAROUND (T),
        .MAX_HOLD   (MH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Model: current owner (-1 = none), last releaser, dead cycles since release, cycles held.
    int       m_owner, m_last, m_dead, m_hold, m_id;
    bit       m_to;
    logic [N-1:0] prev_g = '0;

    function automatic int pick(logic [N-1:0] r, int last);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                int d = (i - last - 1 + 2 * N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_edge(bit rs, logic [N-1:0] r);
        bit forced;
        forced = 1'b0;
        if (rs) begin
            m_owner = -1; m_last = N - 1; m_dead = BIG;
            m_hold = 0; m_id = 0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner >= 0) begin
            m_hold++;
`ifdef ARB_HOLD_TIMEOUT_EN
            forced = r[m_owner] && (m_hold >= MH) && ((r & ~(N'(1) << m_owner)) != '0);
`endif
            if (!r[m_owner] || forced) begin
                m_last  = m_owner;
                m_owner = -1;
                m_dead  = 0;
                m_to    = forced;
            end
        end else begin
            if (m_dead < BIG) m_dead++;
            if (m_dead >= T && r != '0) begin
                m_owner = pick(r, m_last);
                m_id    = m_owner;
                m_hold  = 0;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk({tag, ".gnt"},     32'(bus_if.gnt),     32'(eg));
        chk({tag, ".gnt_id"},  32'(bus_if.gnt_id),  32'(m_id));
        chk({tag, ".drv_en"},  32'(bus_if.drv_en),  32'(m_owner >= 0));
        chk({tag, ".busy"},    32'(bus_if.busy),    32'(m_owner >= 0 || m_dead < T));
        chk({tag, ".timeout"}, 32'(bus_if.timeout), 32'(m_to));
        chk({tag, ".hop"},
            32'(prev_g != '0 && bus_if.gnt != '0 && bus_if.gnt != prev_g), 32'(0));
        prev_g = bus_if.gnt;
    endtask

    task automatic step(logic [N-1:0] r, bit rs, string tag);
        bus_if.req = r;
        rst        = rs;
        @(posedge clk);
        model_edge(rs, r);
        #1;
        check_all(tag);
    endtask

    initial begin
        int           held;
        int           g0cnt;
        int           tocnt;
        int           exp_order [5];
        int           order [$];
        logic [N-1:0] r;
        logic [N-1:0] last_g;
        bit           rs;

        exp_order = '{0, 1, 2, 3, 0};
        bus_if.req = '0;
        rst        = 1'b1;

        // 1: single requester, one-cycle latency
        step(4'b0000, 1'b1, "t1.rst");
        chk("t1.rst_busy", 32'(bus_if.busy), 32'(0));
        step(4'b0100, 1'b0, "t1");
        chk("t1.gnt_const",  32'(bus_if.gnt),    32'(4'b0100));
        chk("t1.id_const",   32'(bus_if.gnt_id), 32'(2));
        chk("t1.busy_const", 32'(bus_if.busy),   32'(1));

        // 2: release then one dead cycle before the next owner
        step(4'b0000, 1'b1, "t2.rst");
        step(4'b0110, 1'b0, "t2.a");
        chk("t2.first", 32'(bus_if.gnt), 32'(4'b0010));
        step(4'b0100, 1'b0, "t2.b");
        chk("t2.dead", 32'(bus_if.drv_en), 32'(0));
        step(4'b0100, 1'b0, "t2.c");
        chk("t2.second", 32'(bus_if.gnt), 32'(4'b0100));

        // 3: all requesting, each owner drops after 3 granted cycles
        step(4'b0000, 1'b1, "t3.rst");
        held   = 0;
        last_g = '0;
        for (int c = 0; c < 20; c++) begin
            r = '1;
            if (m_owner >= 0 && held == 3) r[m_owner] = 1'b0;
            step(r, 1'b0, "t3");
            if (m_owner >= 0) held++; else held = 0;
            if (bus_if.gnt != '0 && last_g == '0) order.push_back(int'(bus_if.gnt_id));
            last_g = bus_if.gnt;
        end
        for (int k = 0; k < 5; k++) begin
            chk("t3.order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF, 32'(exp_order[k]));
        end

        // 4: owner 3 releases, pointer wraps to 0
        step(4'b0000, 1'b1, "t4.rst");
        step(4'b1000, 1'b0, "t4.a");
        step(4'b1001, 1'b0, "t4.b");
        step(4'b0001, 1'b0, "t4.c");
        step(4'b1001, 1'b0, "t4.d");
        chk("t4.wrap", 32'(bus_if.gnt), 32'(4'b0001));

        // 5: reset in the middle of a grant
        step(4'b0000, 1'b1, "t5.rst");
        step(4'b0100, 1'b0, "t5.a");
        step(4'b0100, 1'b1, "t5.b");
        chk("t5.rst_gnt",  32'(bus_if.gnt),  32'(0));
        chk("t5.rst_busy", 32'(bus_if.busy), 32'(0));
        step(4'b0101, 1'b0, "t5.c");
        chk("t5.after", 32'(bus_if.gnt), 32'(4'b0001));

        // 6: long hold with a second requester waiting
        step(4'b0000, 1'b1, "t6.rst");
        g0cnt = 0;
        tocnt = 0;
        for (int i = 0; i < 40; i++) begin
            step((i >= 5) ? 4'b0011 : 4'b0001, 1'b0, "t6");
            if (i < 17) begin
                if (bus_if.gnt == 4'b0001) g0cnt++;
                if (bus_if.timeout) tocnt++;
            end
        end
`ifdef ARB_HOLD_TIMEOUT_EN
        chk("t6.hold_len", 32'(g0cnt), 32'(16));
        chk("t6.timeouts", 32'(tocnt), 32'(1));
`else
        chk("t6.hold_len", 32'(g0cnt), 32'(17));
        chk("t6.timeouts", 32'(tocnt), 32'(0));
`endif

        // random traffic with occasional reset
        step(4'b0000, 1'b1, "rnd.rst");
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            rs = ($urandom_range(99) == 0);
            step(r, rs, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
